// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive FIFO controller: edge-detected push, host pop, RDA/timeout irqs.
// Define UART_RX_TIMEOUT_EN to build the character-timeout logic.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     baud_clk,
  input  logic                     rx_done,
  input  logic [7:0]               rx_data,
  input  logic                     PEN,
  input  logic                     STB,
  input  logic                     OSM_SEL,
  input  logic [1:0]               WLS,
  input  logic [1:0]               trig_lvl,
  input  logic                     rx_flush,
  input  logic                     ovr_clr,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic                     rx_empty,
  output logic                     rx_full,
  output logic                     overrun,
  output logic                     irq_rda,
  output logic                     irq_timeout
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rx_done_q;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          ovr_set;
  logic [AW:0]   thr;

  assign rx_empty = (rx_level == '0);
  assign rx_full  = (rx_level == (AW+1)'(DEPTH));

  assign push    = rx_done & ~rx_done_q;
  assign pop     = rd_en & ~rx_empty & ~rx_flush;
  // a pop frees the head slot, so a push into a full FIFO still lands
  assign wr_en   = push & (~rx_full | pop) & ~rx_flush;
  assign ovr_set = push & rx_full & ~pop & ~rx_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_done_q <= 1'b0;
    else        rx_done_q <= rx_done;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_level <= '0;
    end else begin
      rd_valid <= pop;
      if (pop) rd_data <= mem[rd_ptr];
      if (rx_flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        rx_level <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        case ({wr_en, pop})
          2'b10:   rx_level <= rx_level + 1'b1;
          2'b01:   rx_level <= rx_level - 1'b1;
          default: rx_level <= rx_level;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overrun <= 1'b0;
    else if (rx_flush) overrun <= 1'b0;
    else if (ovr_set)  overrun <= 1'b1;
    else if (ovr_clr)  overrun <= 1'b0;
  end

  always_comb begin
    thr = (AW+1)'(1);
    unique case (trig_lvl)
      2'b01:   thr = (AW+1)'(DEPTH/4);
      2'b10:   thr = (AW+1)'(DEPTH/2);
      2'b11:   thr = (AW+1)'(DEPTH-2);
      default: thr = (AW+1)'(1);
    endcase
  end

  assign irq_rda = (rx_level >= thr);

`ifdef UART_RX_TIMEOUT_EN
  logic [3:0] frame_bits;
  logic [7:0] fb_osr;
  logic [9:0] tout;
  logic [9:0] tcnt;
  logic [9:0] tcnt_nxt;

  // start + (5+WLS) data + parity + (1+STB) stop
  assign frame_bits = 4'd7 + {2'b00, WLS} + {3'b000, PEN} + {3'b000, STB};
  assign fb_osr = OSM_SEL ? ({4'h0, frame_bits} * 8'd13)
                          : {frame_bits, 4'h0};
  assign tout = {fb_osr, 2'b00};

  always_comb begin
    tcnt_nxt = tcnt;
    if (push | pop | rx_flush | rx_empty) tcnt_nxt = '0;
    else if (baud_clk && (tcnt < tout))  tcnt_nxt = tcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt        <= '0;
      irq_timeout <= 1'b0;
    end else begin
      tcnt <= tcnt_nxt;
      if (rx_flush | pop)       irq_timeout <= 1'b0;
      else if (tcnt_nxt >= tout) irq_timeout <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^{baud_clk, PEN, STB, OSM_SEL, WLS};
  assign irq_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl (DEPTH=16, 9-bit frame -> TOUT 576/468).
module tb_uart_rx_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_clk;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       PEN, STB, OSM_SEL;
  logic [1:0] WLS;
  logic [1:0] trig_lvl;
  logic       rx_flush, ovr_clr, rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] rx_level;
  logic       rx_empty, rx_full, overrun;
  logic       irq_rda, irq_timeout;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_ctrl #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk),
    .rx_done(rx_done), .rx_data(rx_data),
    .PEN(PEN), .STB(STB), .OSM_SEL(OSM_SEL), .WLS(WLS),
    .trig_lvl(trig_lvl), .rx_flush(rx_flush), .ovr_clr(ovr_clr),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rx_level(rx_level), .rx_empty(rx_empty), .rx_full(rx_full),
    .overrun(overrun), .irq_rda(irq_rda), .irq_timeout(irq_timeout)
  );

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       rd;
    logic [7:0] e_data;
    logic       e_valid;
    logic [4:0] e_level;
    logic       e_ovr;
    logic       e_rda;
  } vec_t;

  vec_t tbl [11];

  localparam logic [18:0] RST_SNAP = {8'h00, 1'b0, 5'd0, 1'b1, 4'b0000};

  function automatic logic [18:0] snap();
    return {rd_data, rd_valid, rx_level, rx_empty, rx_full,
            overrun, irq_rda, irq_timeout};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      passes++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    step();
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] d);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk(nm, 32'({rd_valid, rd_data}), 32'({1'b1, d}));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      baud_clk = 1'b1;
      step();
      baud_clk = 1'b0;
      repeat (4) step();
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 5'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h3C, 1'b0, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'h7E, 1'b1, 8'h3C, 1'b1, 5'd1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h7E, 1'b1, 5'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h7E, 1'b0, 5'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    baud_clk = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    PEN = 1'b1;
    STB = 1'b1;
    OSM_SEL = 1'b0;
    WLS = 2'b00;
    trig_lvl = 2'b00;
    rx_flush = 1'b0;
    ovr_clr = 1'b0;
    rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(snap()), 32'(RST_SNAP));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // single push from a multi-cycle rx_done, pops, push+pop
    for (int i = 0; i < 11; i++) begin
      rx_done = tbl[i].done;
      rx_data = tbl[i].data;
      rd_en   = tbl[i].rd;
      step();
      chk($sformatf("vec%0d", i), 32'(snap()),
          32'({tbl[i].e_data, tbl[i].e_valid, tbl[i].e_level,
               tbl[i].e_level == 5'd0, tbl[i].e_level == 5'd16,
               tbl[i].e_ovr, tbl[i].e_rda, 1'b0}));
    end
    rx_done = 1'b0;
    rd_en = 1'b0;

    // overflow: 17 pushes, 16 ordered pops, overrun clear
    for (int i = 0; i < 17; i++) push(8'(i));
    chk("full_ovr", 32'({rx_level, rx_full, overrun}),
        32'({5'd16, 1'b1, 1'b1}));
    for (int i = 0; i < 16; i++)
      pop_chk($sformatf("ovf_pop%0d", i), 8'(i));
    chk("empty_after", 32'({rx_empty, overrun}), 32'({1'b1, 1'b1}));
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'(1'b0));

    // full: set beats clear, then push+pop with no overrun
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    rx_data = 8'h66;
    rx_done = 1'b1;
    ovr_clr = 1'b1;
    step();
    rx_done = 1'b0;
    ovr_clr = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'(1'b1));
    step();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_clr2", 32'(overrun), 32'(1'b0));
    rx_data = 8'h55;
    rx_done = 1'b1;
    rd_en = 1'b1;
    step();
    rx_done = 1'b0;
    rd_en = 1'b0;
    chk("full_pushpop", 32'({rd_valid, rd_data, rx_level, overrun}),
        32'({1'b1, 8'h20, 5'd16, 1'b0}));
    step();
    for (int i = 1; i < 16; i++)
      pop_chk($sformatf("pp_pop%0d", i), 8'h20 + 8'(i));
    pop_chk("last_55", 8'h55);

    // trigger levels and flush vs pop
    trig_lvl = 2'b10;
    for (int i = 0; i < 7; i++) push(8'h40 + 8'(i));
    chk("rda_at7", 32'({rx_level, irq_rda}), 32'({5'd7, 1'b0}));
    push(8'h47);
    chk("rda_at8", 32'({rx_level, irq_rda}), 32'({5'd8, 1'b1}));
    trig_lvl = 2'b11;
    #1;
    chk("rda_trig14", 32'(irq_rda), 32'(1'b0));
    trig_lvl = 2'b01;
    #1;
    chk("rda_trig4", 32'(irq_rda), 32'(1'b1));
    rd_en = 1'b1;
    rx_flush = 1'b1;
    step();
    rd_en = 1'b0;
    rx_flush = 1'b0;
    chk("flush_pop", 32'({rx_level, rx_empty, rd_valid, rd_data}),
        32'({5'd0, 1'b1, 1'b0, 8'h55}));
    trig_lvl = 2'b00;

`ifdef UART_RX_TIMEOUT_EN
    push(8'h81);
    tick(575);
    chk("tout576_pre", 32'(irq_timeout), 32'(1'b0));
    tick(1);
    chk("tout576_hit", 32'(irq_timeout), 32'(1'b1));
    pop_chk("tout_pop", 8'h81);
    chk("tout_popclr", 32'(irq_timeout), 32'(1'b0));
    OSM_SEL = 1'b1;
    push(8'h82);
    tick(467);
    chk("tout468_pre", 32'(irq_timeout), 32'(1'b0));
    tick(1);
    chk("tout468_hit", 32'(irq_timeout), 32'(1'b1));
    for (int i = 0; i < 4; i++) push(8'h90 + 8'(i));
    chk("push_keeps_irq", 32'({rx_level, irq_timeout}),
        32'({5'd5, 1'b1}));
`else
    push(8'h81);
    tick(600);
    chk("tout_absent", 32'({rx_level, irq_timeout}), 32'({5'd1, 1'b0}));
    for (int i = 0; i < 4; i++) push(8'h90 + 8'(i));
    chk("level5", 32'(rx_level), 32'(5'd5));
`endif

    // asynchronous reset mid-operation, no clock edge in between
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(snap()), 32'(RST_SNAP));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset", 32'(snap()), 32'(RST_SNAP));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
